dht_reader: RTL and testbench
=============================

// Module: dht_reader
// PURPOSE
//  Parametrised single-wire reader for DHT11/DHT22-class humidity/temperature sensors.
//  Issues the start pulse, decodes the 40-bit frame and verifies the checksum.
//  Retries up to MAX_RETRIES times on failure, then presents a coded error.
//  Sits between the open-drain sensor pad and the register/UART layer; timing is derived from CLK_FREQ_HZ.
// PARAMETERS
//  CLK_FREQ_HZ     50_000_000  system clock frequency; CYC_US = CLK_FREQ_HZ/1_000_000 cycles per us
//  START_LOW_US    18_000      host start-pulse low time (DHT22 boards may use 1_000)
//  RESP_TIMEOUT_US 100         max wait for each sensor response edge (release->low, low->high, high->low)
//  BIT_TIMEOUT_US  100         max duration of any single bit low or high phase
//  BIT_THRESH_US   50          bit high phase > threshold => 1, else 0
//  COOLDOWN_US     1_000_000   line-idle time after any attempt before next attempt or new start
//  MAX_RETRIES     2           extra attempts after first failure (0..7)
// PORTS
//  clock             in    1  system clock
//  reset             in    1  synchronous, active-high
//  start             in    1  request one measurement; sampled only in IDLE
//  transmission_line inout 1  sensor data pin; driven 0 or released to Z, never driven 1
//  busy              out   1  high from accepted start until return to IDLE (includes cooldown)
//  data_valid        out   1  one-cycle pulse when a checksum-correct frame is latched
//  hum_int           out   8  humidity integer byte (frame[39:32])
//  hum_float         out   8  humidity fractional byte (frame[31:24])
//  temp_int          out   8  temperature integer byte (frame[23:16])
//  temp_float        out   8  temperature fractional byte (frame[15:8])
//  checksum          out   8  received checksum byte (frame[7:0])
//  error             out   1  high after a measurement finally failed; cleared by next accepted start
//  error_code        out   3  0 none, 1 no response, 2 sync timeout, 3 bit timeout, 4 checksum mismatch
//  debug             out   1  last decoded bit value, updated per bit
// BEHAVIOUR
//  - Clock is named clock; reset is synchronous, active-high. All outputs 0 in reset; line released (Z).
//  - Reset mid-operation: line released on the same edge; state IDLE; counters, retries and outputs cleared.
//  - The line is sampled through a 2-flop synchroniser; all edge decisions use the synchronised value.
//  - FSM:
//    IDLE:      start=1 -> busy=1, error=0, error_code=0, retry_cnt=0 -> START_LOW.
//    START_LOW: drive 0 for START_LOW_US*CYC_US cycles -> RELEASE.
//    RELEASE:   line Z; wait for low. Timeout: error 1 (no response).
//    RESP_LOW:  wait for high. Timeout: error 2 (sync timeout).
//    RESP_HIGH: wait for low. Timeout: error 2 (sync timeout). On low, bit_idx=39 -> BIT_LOW.
//    BIT_LOW:   wait for high. Timeout: error 3 (bit timeout).
//    BIT_HIGH:  count cycles while high. On the falling edge, frame[bit_idx] = (count > BIT_THRESH_US*CYC_US).
//               If bit_idx==0 -> CHECK, else decrement bit_idx -> BIT_LOW. Timeout: error 3 (bit timeout).
//    CHECK:     if (sum of bytes 4..1) mod 256 == byte0, latch all five outputs and pulse data_valid for 1 cycle.
//               Otherwise error 4 (checksum mismatch). Either way -> COOLDOWN.
//    COOLDOWN:  line Z for COOLDOWN_US*CYC_US cycles. Then, if a failure is pending:
//               retry_cnt<MAX_RETRIES -> retry_cnt++ -> START_LOW; otherwise set error/error_code -> IDLE.
//               No failure pending -> IDLE.
//  - Any error N: record code N, release the line, -> COOLDOWN.
//  - Data outputs keep the last good frame. A failed attempt never modifies them.
//  - error_code holds the last failure cause until the next accepted start.
//  - start while busy is ignored; no queueing. Counter width: $clog2(max cycle count)+1; saturates, never wraps.
//  - data_valid latency: exactly 2 cycles after the synchronised final falling edge (CHECK, then output register).
// TESTING
//  T1 sensor model sends 0x35,0x00,0x18,0x00,0x4D -> data_valid pulse; hum_int=0x35, temp_int=0x18, error=0, line driven low 18ms.
//  T2 model silent -> 3 attempts (MAX_RETRIES=2), each separated by cooldown; error=1, error_code=1, outputs unchanged.
//  T3 checksum byte 0x4C; first attempt bad, second good -> single data_valid, error=0, error_code=0.
//  T4 model holds line high 200us mid-bit 12 on every attempt -> error_code=3, busy falls after the final cooldown.
//  T5 reset asserted during BIT_HIGH -> next cycle line Z, busy=0, all outputs 0; following start completes normally.
//  T6 start pulsed while busy and during cooldown -> ignored; exactly one measurement runs.

Source files
------------

// File: rtl/dht_reader.sv
// dht_reader: single-wire reader for DHT11/DHT22-class humidity/temperature sensors.
// Issues the host start pulse, decodes the 40-bit frame, verifies the checksum and
// retries up to MAX_RETRIES times before reporting a coded error.
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   start               measurement request, honoured only while idle
//   transmission_line   open-drain sensor pin (driven 0 or released to Z)
//   busy                high from accepted start until back in idle (incl. cooldown)
//   data_valid          one-cycle pulse when a checksum-correct frame is latched
//   hum_int..checksum   bytes of the last good frame
//   error, error_code   final failure flag and cause (1 no resp, 2 sync, 3 bit, 4 checksum)
//   debug               last decoded bit value
module dht_reader #(
    parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
    parameter int unsigned START_LOW_US    = 18_000,
    parameter int unsigned RESP_TIMEOUT_US = 100,
    parameter int unsigned BIT_TIMEOUT_US  = 100,
    parameter int unsigned BIT_THRESH_US   = 50,
    parameter int unsigned COOLDOWN_US     = 1_000_000,
    parameter int unsigned MAX_RETRIES     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    inout  wire        transmission_line,
    output logic       busy,
    output logic       data_valid,
    output logic [7:0] hum_int,
    output logic [7:0] hum_float,
    output logic [7:0] temp_int,
    output logic [7:0] temp_float,
    output logic [7:0] checksum,
    output logic       error,
    output logic [2:0] error_code,
    output logic       debug
);

    localparam int unsigned CYC_US     = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned START_CYC  = START_LOW_US * CYC_US;
    localparam int unsigned RESP_CYC   = RESP_TIMEOUT_US * CYC_US;
    localparam int unsigned BIT_CYC    = BIT_TIMEOUT_US * CYC_US;
    localparam int unsigned THRESH_CYC = BIT_THRESH_US * CYC_US;
    localparam int unsigned COOL_CYC   = COOLDOWN_US * CYC_US;
    localparam int unsigned MAX_A      = (START_CYC > COOL_CYC) ? START_CYC : COOL_CYC;
    localparam int unsigned MAX_B      = (RESP_CYC > BIT_CYC) ? RESP_CYC : BIT_CYC;
    localparam int unsigned MAX_CYC    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W      = $clog2(MAX_CYC) + 1;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_RESP  = 3'd1;
    localparam logic [2:0] ERR_SYNC  = 3'd2;
    localparam logic [2:0] ERR_BIT   = 3'd3;
    localparam logic [2:0] ERR_CHECK = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH,
        S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_COOLDOWN
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [5:0]       bit_idx_q;
    logic [39:0]      frame_q;
    logic [2:0]       retry_q;
    logic             fail_pend_q;
    logic [2:0]       fail_code_q;
    logic             drive_low_q;
    logic [2:0]       sync_q;
    logic             busy_q, data_valid_q, error_q, debug_q;
    logic [2:0]       error_code_q;
    logic [7:0]       hum_int_q, hum_float_q, temp_int_q, temp_float_q, checksum_q;

    logic             line_s_c, fall_c, bit_c, fail_c;
    logic [2:0]       fail_code_c;
    logic [7:0]       sum_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // Open-drain pad: only ever pull low, otherwise release.
    assign transmission_line = drive_low_q ? 1'b0 : 1'bz;

    assign busy       = busy_q;
    assign data_valid = data_valid_q;
    assign hum_int    = hum_int_q;
    assign hum_float  = hum_float_q;
    assign temp_int   = temp_int_q;
    assign temp_float = temp_float_q;
    assign checksum   = checksum_q;
    assign error      = error_q;
    assign error_code = error_code_q;
    assign debug      = debug_q;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clock) begin
        if (reset) sync_q <= 3'b111;
        else       sync_q <= {sync_q[1:0], transmission_line};
    end

    // Timeout / checksum failure detection for the current state.
    always_comb begin
        line_s_c    = sync_q[1];
        fall_c      = sync_q[2] & ~sync_q[1];
        cnt_inc_c   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        bit_c       = (cnt_q > CNT_W'(THRESH_CYC));
        sum_c       = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
        fail_c      = 1'b0;
        fail_code_c = ERR_NONE;
        case (state_q)
            S_RELEASE:   if (!fall_c && cnt_q >= CNT_W'(RESP_CYC)) begin fail_c = 1'b1; fail_code_c = ERR_RESP; end
            S_RESP_LOW:  if (!line_s_c && cnt_q >= CNT_W'(RESP_CYC)) begin fail_c = 1'b1; fail_code_c = ERR_SYNC; end
            S_RESP_HIGH: if (line_s_c && cnt_q >= CNT_W'(RESP_CYC)) begin fail_c = 1'b1; fail_code_c = ERR_SYNC; end
            S_BIT_LOW:   if (!line_s_c && cnt_q >= CNT_W'(BIT_CYC)) begin fail_c = 1'b1; fail_code_c = ERR_BIT; end
            S_BIT_HIGH:  if (line_s_c && cnt_q >= CNT_W'(BIT_CYC)) begin fail_c = 1'b1; fail_code_c = ERR_BIT; end
            S_CHECK:     if (sum_c != frame_q[7:0]) begin fail_c = 1'b1; fail_code_c = ERR_CHECK; end
            default: ;
        endcase
    end

    // Measurement FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            frame_q      <= '0;
            retry_q      <= '0;
            fail_pend_q  <= 1'b0;
            fail_code_q  <= ERR_NONE;
            drive_low_q  <= 1'b0;
            busy_q       <= 1'b0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
            error_code_q <= ERR_NONE;
            debug_q      <= 1'b0;
            hum_int_q    <= '0;
            hum_float_q  <= '0;
            temp_int_q   <= '0;
            temp_float_q <= '0;
            checksum_q   <= '0;
        end else begin
            data_valid_q <= 1'b0;
            if (fail_c) begin
                // Record the cause; the retry decision is made once the line has rested.
                fail_pend_q <= 1'b1;
                fail_code_q <= fail_code_c;
                drive_low_q <= 1'b0;
                cnt_q       <= '0;
                state_q     <= S_COOLDOWN;
            end else begin
                case (state_q)
                    S_IDLE: if (start) begin
                        busy_q       <= 1'b1;
                        error_q      <= 1'b0;
                        error_code_q <= ERR_NONE;
                        retry_q      <= '0;
                        fail_pend_q  <= 1'b0;
                        fail_code_q  <= ERR_NONE;
                        cnt_q        <= '0;
                        drive_low_q  <= 1'b1;
                        state_q      <= S_START_LOW;
                    end
                    S_START_LOW: if (cnt_q == CNT_W'(START_CYC - 1)) begin
                        drive_low_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_RELEASE;
                    end else cnt_q <= cnt_inc_c;
                    // Require a true falling edge: the synchroniser still shows our own start pulse.
                    S_RELEASE: if (fall_c) begin
                        cnt_q   <= '0;
                        state_q <= S_RESP_LOW;
                    end else cnt_q <= cnt_inc_c;
                    S_RESP_LOW: if (line_s_c) begin
                        cnt_q   <= '0;
                        state_q <= S_RESP_HIGH;
                    end else cnt_q <= cnt_inc_c;
                    S_RESP_HIGH: if (!line_s_c) begin
                        cnt_q     <= '0;
                        bit_idx_q <= 6'd39;
                        state_q   <= S_BIT_LOW;
                    end else cnt_q <= cnt_inc_c;
                    S_BIT_LOW: if (line_s_c) begin
                        cnt_q   <= '0;
                        state_q <= S_BIT_HIGH;
                    end else cnt_q <= cnt_inc_c;
                    S_BIT_HIGH: if (!line_s_c) begin
                        frame_q[bit_idx_q] <= bit_c;
                        debug_q            <= bit_c;
                        cnt_q              <= '0;
                        if (bit_idx_q == 6'd0) begin
                            state_q <= S_CHECK;
                        end else begin
                            bit_idx_q <= bit_idx_q - 6'd1;
                            state_q   <= S_BIT_LOW;
                        end
                    end else cnt_q <= cnt_inc_c;
                    S_CHECK: begin
                        hum_int_q    <= frame_q[39:32];
                        hum_float_q  <= frame_q[31:24];
                        temp_int_q   <= frame_q[23:16];
                        temp_float_q <= frame_q[15:8];
                        checksum_q   <= frame_q[7:0];
                        data_valid_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= S_COOLDOWN;
                    end
                    S_COOLDOWN: if (cnt_q == CNT_W'(COOL_CYC - 1)) begin
                        cnt_q <= '0;
                        if (fail_pend_q && retry_q < 3'(MAX_RETRIES)) begin
                            retry_q     <= retry_q + 3'd1;
                            fail_pend_q <= 1'b0;
                            drive_low_q <= 1'b1;
                            state_q     <= S_START_LOW;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                            if (fail_pend_q) begin
                                error_q      <= 1'b1;
                                error_code_q <= fail_code_q;
                            end
                        end
                    end else cnt_q <= cnt_inc_c;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dht_reader.sv
// Directed bench for dht_reader with a behavioural open-drain sensor model.
// Timing is scaled down: 1 cycle per us, 20 us start pulse, 300 us cooldown.
module tb_dht_reader;
    localparam int unsigned CLK_HZ   = 1_000_000;
    localparam int unsigned START_US = 20;
    localparam int unsigned COOL_US  = 300;
    localparam int unsigned BUDGET   = 20000;

    logic       clock = 1'b0;
    logic       reset, start;
    wire        dht_line;
    logic       busy, data_valid, error, debug;
    logic [7:0] hum_int, hum_float, temp_int, temp_float, checksum;
    logic [2:0] error_code;

    int vectors = 0;
    int miscompares = 0;

    // Sensor model state
    logic        sens_drive;
    int          sens_mode;      // 0 normal, 1 silent, 2 stall high at bit 12
    logic [39:0] frame_first, frame_retry;
    int          base_attempt, attempt_cnt, last_low, sens_bit;
    bit          sens_high, sens_active, sens_abort, busy_at_stall_end;
    int          ncyc = 0, dv_cnt = 0, fall_cyc, stall_cyc;

    assign dht_line = sens_drive ? 1'b0 : 1'bz;
    pullup (dht_line);

    always #5 clock = ~clock;
    always @(posedge clock) ncyc++;
    always @(negedge clock) if (data_valid === 1'b1) dv_cnt++;

    dht_reader #(
        .CLK_FREQ_HZ(CLK_HZ), .START_LOW_US(START_US), .RESP_TIMEOUT_US(100),
        .BIT_TIMEOUT_US(100), .BIT_THRESH_US(50), .COOLDOWN_US(COOL_US), .MAX_RETRIES(2)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .transmission_line(dht_line),
        .busy(busy), .data_valid(data_valid), .hum_int(hum_int), .hum_float(hum_float),
        .temp_int(temp_int), .temp_float(temp_float), .checksum(checksum),
        .error(error), .error_code(error_code), .debug(debug)
    );

    task automatic sens_hold(input logic low, input int n);
        sens_drive = low;
        for (int k = 0; k < n && !sens_abort; k++) @(negedge clock);
    endtask

    // Sensor: answers each host start pulse according to sens_mode.
    initial begin : sensor_model
        logic [39:0] fr;
        int lowc;
        bit stalled;
        sens_drive = 1'b0; attempt_cnt = 0; sens_bit = -1; sens_high = 0;
        sens_active = 0; sens_abort = 0; last_low = 0;
        forever begin
            @(negedge clock);
            if (dht_line === 1'b0 && !sens_drive) begin
                sens_active = 1;
                lowc = 0;
                while (dht_line === 1'b0 && lowc < 100000) begin lowc++; @(negedge clock); end
                last_low = lowc;
                fr = (attempt_cnt == base_attempt) ? frame_first : frame_retry;
                attempt_cnt++;
                stalled = 0;
                if (sens_mode != 1) begin
                    sens_hold(1'b0, 30);
                    sens_hold(1'b1, 80);
                    sens_hold(1'b0, 80);
                    for (int i = 39; i >= 0; i--) begin
                        if (sens_abort) break;
                        sens_hold(1'b1, 50);
                        sens_bit = i;
                        if (sens_mode == 2 && i == 12) begin
                            stall_cyc = ncyc;
                            sens_hold(1'b0, 200);
                            busy_at_stall_end = busy;
                            stalled = 1;
                            break;
                        end
                        sens_high = 1;
                        sens_hold(1'b0, fr[i] ? 70 : 26);
                        sens_high = 0;
                    end
                    if (!stalled && !sens_abort) begin
                        fall_cyc = ncyc;
                        sens_hold(1'b1, 50);
                    end
                end
                sens_drive = 1'b0;
                sens_high = 0;
                sens_bit = -1;
                sens_active = 0;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        int n = 0;
        while (busy === 1'b1 && n < max_cyc) begin @(negedge clock); n++; end
        ok = (busy === 1'b0);
    endtask

    task automatic wait_dv(input int max_cyc, output bit ok);
        int n = 0;
        while (data_valid !== 1'b1 && n < max_cyc) begin @(negedge clock); n++; end
        ok = (data_valid === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        repeat (4) @(negedge clock);
        vectors++; if ({busy, data_valid, error, error_code, debug} !== 7'd0) begin miscompares++; $display("FAIL reset_flags got %b want 0", {busy, data_valid, error, error_code, debug}); end
        vectors++; if ({hum_int, hum_float, temp_int, temp_float, checksum} !== 40'd0) begin miscompares++; $display("FAIL reset_data got %h want 0", {hum_int, hum_float, temp_int, temp_float, checksum}); end
        vectors++; if (dht_line !== 1'b1) begin miscompares++; $display("FAIL reset_line got %b want 1 (released)", dht_line); end
        reset = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_good_frame();
        bit ok;
        int a0, d0;
        sens_mode = 0; base_attempt = attempt_cnt; a0 = attempt_cnt; d0 = dv_cnt;
        frame_first = {8'h35, 8'h00, 8'h18, 8'h00, 8'h4D}; frame_retry = frame_first;
        pulse_start();
        wait_dv(BUDGET, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL good_dv_timeout got none want pulse"); end
        vectors++; if (hum_int !== 8'h35 || hum_float !== 8'h00) begin miscompares++; $display("FAIL good_hum got %h%h want 3500", hum_int, hum_float); end
        vectors++; if (temp_int !== 8'h18 || temp_float !== 8'h00) begin miscompares++; $display("FAIL good_temp got %h%h want 1800", temp_int, temp_float); end
        vectors++; if (checksum !== 8'h4D || error !== 1'b0) begin miscompares++; $display("FAIL good_csum got %h err %b want 4d err 0", checksum, error); end
        vectors++; if (last_low != START_US) begin miscompares++; $display("FAIL start_low_len got %0d want %0d", last_low, START_US); end
        vectors++; if (ncyc - fall_cyc != 4) begin miscompares++; $display("FAIL dv_latency got %0d want 4", ncyc - fall_cyc); end
        vectors++; if (debug !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL good_debug_busy got %b%b want 11", debug, busy); end
        @(negedge clock);
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL dv_width got %b want 0", data_valid); end
        wait_idle(BUDGET, ok);
        vectors++; if (!ok || attempt_cnt - a0 != 1 || dv_cnt - d0 != 1) begin miscompares++; $display("FAIL good_counts idle %b attempts %0d dv %0d want 1 1 1", ok, attempt_cnt - a0, dv_cnt - d0); end
    endtask

    task automatic test_no_response();
        bit ok;
        int a0, d0;
        sens_mode = 1; base_attempt = attempt_cnt; a0 = attempt_cnt; d0 = dv_cnt;
        pulse_start();
        wait_idle(BUDGET, ok);
        vectors++; if (!ok || attempt_cnt - a0 != 3) begin miscompares++; $display("FAIL noresp_attempts idle %b got %0d want 3", ok, attempt_cnt - a0); end
        vectors++; if (error !== 1'b1 || error_code !== 3'd1) begin miscompares++; $display("FAIL noresp_err got %b/%0d want 1/1", error, error_code); end
        vectors++; if (hum_int !== 8'h35 || checksum !== 8'h4D || dv_cnt != d0) begin miscompares++; $display("FAIL noresp_hold got %h %h dv %0d want 35 4d 0", hum_int, checksum, dv_cnt - d0); end
        sens_mode = 0;
    endtask

    task automatic test_checksum_retry();
        bit ok;
        int a0, d0;
        sens_mode = 0; base_attempt = attempt_cnt; a0 = attempt_cnt; d0 = dv_cnt;
        frame_first = {8'h3C, 8'h01, 8'h19, 8'h05, 8'h5A};
        frame_retry = {8'h3C, 8'h01, 8'h19, 8'h05, 8'h5B};
        pulse_start();
        vectors++; if (error !== 1'b0 || error_code !== 3'd0 || busy !== 1'b1) begin miscompares++; $display("FAIL start_clears_err got %b/%0d busy %b want 0/0 1", error, error_code, busy); end
        wait_idle(BUDGET, ok);
        vectors++; if (!ok || attempt_cnt - a0 != 2 || dv_cnt - d0 != 1) begin miscompares++; $display("FAIL csum_counts idle %b attempts %0d dv %0d want 1 2 1", ok, attempt_cnt - a0, dv_cnt - d0); end
        vectors++; if (error !== 1'b0 || error_code !== 3'd0) begin miscompares++; $display("FAIL csum_err got %b/%0d want 0/0", error, error_code); end
        vectors++; if ({hum_int, hum_float, temp_int, temp_float, checksum} !== 40'h3C0119055B) begin miscompares++; $display("FAIL csum_data got %h want 3c0119055b", {hum_int, hum_float, temp_int, temp_float, checksum}); end
    endtask

    task automatic test_bit_timeout();
        bit ok;
        int a0, d0;
        sens_mode = 2; base_attempt = attempt_cnt; a0 = attempt_cnt; d0 = dv_cnt;
        frame_first = {8'h35, 8'h00, 8'h18, 8'h00, 8'h4D}; frame_retry = frame_first;
        busy_at_stall_end = 0;
        pulse_start();
        wait_idle(BUDGET, ok);
        vectors++; if (!ok || attempt_cnt - a0 != 3) begin miscompares++; $display("FAIL bitto_attempts idle %b got %0d want 3", ok, attempt_cnt - a0); end
        vectors++; if (error !== 1'b1 || error_code !== 3'd3) begin miscompares++; $display("FAIL bitto_err got %b/%0d want 1/3", error, error_code); end
        vectors++; if (!busy_at_stall_end || ncyc - stall_cyc < 400 || ncyc - stall_cyc > 410) begin miscompares++; $display("FAIL bitto_busy_fall busy %b after %0d want 1 400..410", busy_at_stall_end, ncyc - stall_cyc); end
        vectors++; if (checksum !== 8'h5B || dv_cnt != d0) begin miscompares++; $display("FAIL bitto_hold got %h dv %0d want 5b 0", checksum, dv_cnt - d0); end
        sens_mode = 0;
    endtask

    task automatic test_start_ignored();
        bit ok;
        int a0, d0;
        sens_mode = 0; base_attempt = attempt_cnt; a0 = attempt_cnt; d0 = dv_cnt;
        frame_first = {8'h40, 8'h02, 8'h1A, 8'h03, 8'h5F}; frame_retry = frame_first;
        pulse_start();
        repeat (100) @(negedge clock);
        pulse_start();
        wait_dv(BUDGET, ok);
        repeat (50) @(negedge clock);
        pulse_start();
        wait_idle(BUDGET, ok);
        repeat (20) @(negedge clock);
        vectors++; if (!ok || busy !== 1'b0 || attempt_cnt - a0 != 1 || dv_cnt - d0 != 1) begin miscompares++; $display("FAIL busy_start busy %b attempts %0d dv %0d want 0 1 1", busy, attempt_cnt - a0, dv_cnt - d0); end
        vectors++; if (hum_int !== 8'h40 || temp_int !== 8'h1A || checksum !== 8'h5F) begin miscompares++; $display("FAIL busy_data got %h %h %h want 40 1a 5f", hum_int, temp_int, checksum); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        sens_mode = 0; base_attempt = attempt_cnt;
        frame_first = {8'h35, 8'h00, 8'h18, 8'h00, 8'h4D}; frame_retry = frame_first;
        pulse_start();
        n = 0;
        while (!(sens_bit == 20 && sens_high) && n < BUDGET) begin @(negedge clock); n++; end
        vectors++; if (n >= BUDGET) begin miscompares++; $display("FAIL rstmid_reach got timeout want bit 20"); end
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        vectors++; if ({busy, data_valid, error, error_code, debug} !== 7'd0 || dht_line !== 1'b1) begin miscompares++; $display("FAIL rstmid_flags got %b line %b want 0 1", {busy, data_valid, error, error_code, debug}, dht_line); end
        vectors++; if ({hum_int, hum_float, temp_int, temp_float, checksum} !== 40'd0) begin miscompares++; $display("FAIL rstmid_data got %h want 0", {hum_int, hum_float, temp_int, temp_float, checksum}); end
        sens_abort = 1;
        reset = 1'b0;
        n = 0;
        while (sens_active && n < 1000) begin @(negedge clock); n++; end
        sens_abort = 0;
        repeat (20) @(negedge clock);
        base_attempt = attempt_cnt;
        pulse_start();
        wait_dv(BUDGET, ok);
        vectors++; if (!ok || {hum_int, temp_int, checksum} !== 24'h35184D || error !== 1'b0) begin miscompares++; $display("FAIL rstmid_after dv %b got %h err %b want 1 35184d 0", ok, {hum_int, temp_int, checksum}, error); end
        wait_idle(BUDGET, ok);
    endtask

    initial begin : main
        reset = 1'b1; start = 1'b0;
        sens_mode = 0; base_attempt = 0;
        frame_first = '0; frame_retry = '0; fall_cyc = 0; stall_cyc = 0; busy_at_stall_end = 0;
        test_reset();
        test_good_frame();
        test_no_response();
        test_checksum_retry();
        test_bit_timeout();
        test_start_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
